// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus MMIO page with cycle counter,
// LED register and a byte TX FIFO drained over valid/ready.
module dmem_responder #(
  parameter int unsigned RAM_DEPTH  = 64,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_we,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic [7:0]  led,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int unsigned ADDR_W = $clog2(RAM_DEPTH);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  localparam logic [31:0] RAM_BYTES =
    32'(4 * RAM_DEPTH);
  localparam logic [CNT_W-1:0] CNT_FULL =
    CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE =
    CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE =
    PTR_W'(1);

  typedef enum logic [1:0] {
    OFF_CYCLE  = 2'd0,
    OFF_LED    = 2'd1,
    OFF_TX     = 2'd2,
    OFF_STATUS = 2'd3
  } mmio_off_e;

  // Address decode
  logic              ram_sel;
  logic              mmio_sel;
  mmio_off_e         off;
  logic [ADDR_W-1:0] ram_idx;

  assign ram_sel  = addr < RAM_BYTES;
  assign mmio_sel = addr[31:4] == MMIO_BASE[31:4];
  assign off      = mmio_off_e'(addr[3:2]);
  assign ram_idx  = addr[ADDR_W+1:2];

  // Reset outranks every write, RAM included
  logic wr_en;
  logic ram_we;
  logic cyc_we;
  logic led_we;
  logic tx_we;
  logic st_we;

  assign wr_en  = mem_we && !rst;
  assign ram_we = wr_en && ram_sel;
  assign cyc_we = wr_en && mmio_sel && off == OFF_CYCLE;
  assign led_we = wr_en && mmio_sel && off == OFF_LED;
  assign tx_we  = wr_en && mmio_sel && off == OFF_TX;
  assign st_we  = wr_en && mmio_sel && off == OFF_STATUS;

  // Word RAM, never cleared
  logic [31:0] ram_mem [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_mem[ram_idx] <= write_data;
    end
  end

  // Register state
  logic [31:0]      cycle_q,  cycle_d;
  logic [7:0]       led_q,    led_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             ovf_q,    ovf_d;

  logic fifo_full;
  logic fifo_empty;
  logic pop;
  logic push;
  logic ovf_set;
  logic ovf_clr;

  assign fifo_full  = count_q == CNT_FULL;
  assign fifo_empty = count_q == '0;
  assign pop        = !fifo_empty && tx_ready;
  assign push       = tx_we && (!fifo_full || pop);
  assign ovf_set    = tx_we && fifo_full && !pop;
  assign ovf_clr    = st_we && write_data[2];

  always_comb begin
    cycle_d  = cycle_q + 32'd1;
    led_d    = led_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (cyc_we) begin
      cycle_d = write_data;
    end
    if (led_we) begin
      led_d = write_data[7:0];
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // A drop in the same cycle as a clear must stay visible
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q  <= '0;
      led_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      cycle_q  <= cycle_d;
      led_q    <= led_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage; contents are don't-care after reset
  logic [7:0] fifo_mem [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= write_data[7:0];
    end
  end

  assign tx_data  = fifo_mem[rd_ptr_q];
  assign tx_valid = !fifo_empty;
  assign led      = led_q;

  // Combinational load path
  logic [31:0] status;

  assign status = {16'b0, 8'(count_q), 5'b0,
                   ovf_q, fifo_full, fifo_empty};

  always_comb begin
    read_data = '0;
    if (ram_sel) begin
      read_data = ram_mem[ram_idx];
    end else if (mmio_sel) begin
      unique case (off)
        OFF_CYCLE:  read_data = cycle_q;
        OFF_LED:    read_data = {24'b0, led_q};
        OFF_TX:     read_data = '0;
        OFF_STATUS: read_data = status;
        default:    read_data = '0;
      endcase
    end
  end

endmodule
